// File: rtl/vae_fixed_pkg.sv
// Shared fixed-point definitions for the VAE level-1 datapath (sqr/sqrt pair).
// Holds the Q-format defaults and the start/busy/valid handshake state encoding.
package vae_fixed_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FBITS = 8;

  // Integer value of 1.0 in the default Q format
  localparam int Q_ONE = 1 << DEF_FBITS;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/sqr.sv
// Sequential fixed-point squarer: iterative shift-add, one operand bit per cycle,
// saturating to all-ones when the square exceeds the Q-format range.
module sqr
  import vae_fixed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FBITS = DEF_FBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] sq,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] sq_q, sq_d;
  logic             ovf_q, ovf_d;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    accSum;
  logic             lastIter;
  logic             prodOvf;

  // The multiplicand shifts left each cycle, so it always carries the weight
  // of the multiplier bit currently at the LSB.
  assign addend   = mplier_q[0] ? mcand_q : '0;
  assign accSum   = acc_q + addend;
  assign lastIter = (cnt_q == CW'(WIDTH - 1));
  assign prodOvf  = |accSum[PW-1:WIDTH+FBITS];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sq_d     = sq_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, x};
          mplier_d = x;
          acc_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d    = accSum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (lastIter) begin
          state_d = ST_DONE;
          ovf_d   = prodOvf;
          sq_d    = prodOvf ? '1 : accSum[WIDTH+FBITS-1:FBITS];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sq_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sq_q     <= sq_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy  = (state_q == ST_CALC);
  assign valid = (state_q == ST_DONE);
  assign sq    = sq_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/sqr.md
# sqr

Sequential fixed-point squarer, the inverse companion of the `sqrt` unit in the VAE level-1 datapath. It takes a signed-magnitude-free unsigned Qm.n operand and returns its square in the same Q format. It uses the same start/busy/valid handshake as `sqrt`, so the two blocks can be chained for round-trip checking (`sqr(sqrt(x)) ≈ x`) and for variance/std-dev recomputation. The datapath is an iterative shift-add multiplier, one operand bit per cycle, with saturation on overflow.

## Interface
- `WIDTH`, 16: operand and result width in bits.
- `FBITS`, 8: fractional bits. Q(WIDTH−FBITS).FBITS, default Q8.8.
- `clk` input, 1: clock; all logic on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: begin a calculation on `x`. Accepted only when idle.
- `busy` output, 1: calculation in progress.
- `valid` output, 1: one-cycle pulse; `sq` and `ovf` are fresh.
- `x` input, WIDTH: operand, unsigned Q format, sampled on the accepting edge.
- `sq` output, WIDTH: x² in Q format, truncated, saturated on overflow.
- `ovf` output, 1: the true square exceeded the representable range.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - CALC: `busy`=1, bit counter runs 0..WIDTH−1.
  - DONE: `busy`=0, `valid`=1 for exactly one cycle.
- Transitions:
  - IDLE→CALC on `start`.
  - CALC→DONE when the counter reaches WIDTH−1.
  - DONE→CALC if `start` is asserted in DONE; otherwise DONE→IDLE.
- On accept, the operand is latched into a multiplicand register and a multiplier shift register. The 2·WIDTH-bit accumulator is cleared.
- Each CALC cycle: if the multiplier LSB is 1, add the multiplicand (shifted by the iteration count) into the accumulator. Then shift the multiplier right by one.
- At CALC→DONE, with full product P (2·WIDTH bits):
  - `ovf` = |P[2·WIDTH−1 : WIDTH+FBITS].
  - `sq` = ovf ? all-ones : P[WIDTH+FBITS−1 : FBITS]. No rounding; the fractional LSBs below FBITS are truncated.
- `sq` and `ovf` hold their values until the next result is written. They do not change during a later CALC.
- `start` asserted in CALC is ignored. There is no queueing, and `x` changes in CALC have no effect.
- `x` = 0 takes the full WIDTH cycles; there is no early termination.
- Reset mid-operation:
  - The FSM returns to IDLE.
  - `busy`, `valid`, `ovf` go to 0 and `sq` goes to 0 on the next edge.
  - The partial result is discarded.
- Reset has priority over `start` on the same edge.

## Timing
- Reset values: `busy`=0, `valid`=0, `sq`=0, `ovf`=0.
- `start` sampled high at edge k while idle:
  - `busy`=1 for cycles k+1 .. k+WIDTH (WIDTH cycles).
  - `valid`=1 and the new `sq`/`ovf` appear in cycle k+WIDTH+1.
  - Latency is WIDTH+1 cycles, 17 at default.
- Back-to-back: `start` held high during the DONE cycle is accepted. `busy` rises again the following cycle, so the throughput is one result per WIDTH+1 cycles.
- `busy` and `valid` are never high in the same cycle.

## Structure
- Shared package `vae_fixed_pkg`:
  - defaults `WIDTH`=16 and `FBITS`=8;
  - the Q-format scaling constant;
  - the 2-bit state encoding (IDLE/CALC/DONE), shared with the `sqrt` handshake.
- No sub-module is required. The shift-add step and the saturation/extract logic stay in `sqr`.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `start`=1 → `busy`=0, `valid`=0, `sq`=0x0000, `ovf`=0.
- **Exact square:** `x`=0x0F40 (15.25) → after 17 cycles, `valid` pulse, `sq`=0xE890 (232.5625), `ovf`=0.
- **Fractional operand and truncation:**
  - `x`=0x0080 (0.5) → `sq`=0x0040 (0.25).
  - `x`=0x016A (1.4140625) → `sq`=0x01FF (P=131044, truncated), `ovf`=0.
- **Overflow:**
  - `x`=0x1000 (16.0) → `sq`=0xFFFF, `ovf`=1.
  - `x`=0x0FFF → `sq`=0xFFE0, `ovf`=0 (largest non-overflowing operand).
- **Handshake:**
  - `start` pulsed again at cycle k+5 with a different `x` → ignored; the result still equals the first operand's square.
  - `start` held during the DONE cycle → second result `valid` exactly 17 cycles after the first.
- **Reset mid-CALC:** assert `rst` at cycle k+8 → next cycle `busy`=0 and `sq`=0, and no `valid` pulse follows.
